// File: rtl/rat_int_ctrl.sv
// RAT MCU interrupt controller: synchronises and edge-detects eight sources,
// latches them as pending, masks them and drives a stretched INTR pulse with ISR hand-shake.
module rat_int_ctrl #(
    parameter logic [7:0]  MASK_ID     = 8'h44,
    parameter logic [7:0]  CLEAR_ID    = 8'h45,
    parameter logic [7:0]  STATUS_ID   = 8'h21,
    parameter int unsigned INTR_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] SRC,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_DATA,
    output logic       INTR,
    output logic [7:0] PENDING,
    output logic [7:0] MASK
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(INTR_CYCLES - 1);

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_s3;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_intr;

    logic       w_mask_wr;
    logic       w_clr_wr;
    logic [7:0] w_clr_bits;
    logic [7:0] w_edge;
    logic [7:0] w_active;

    assign w_mask_wr  = IO_STRB && (PORT_ID == MASK_ID);
    assign w_clr_wr   = IO_STRB && (PORT_ID == CLEAR_ID);
    assign w_clr_bits = w_clr_wr ? OUT_PORT : 8'h00;
    assign w_edge     = r_s2 & ~r_s3;
    assign w_active   = r_pending & r_mask;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_s1      <= 8'h00;
            r_s2      <= 8'h00;
            r_s3      <= 8'h00;
            r_pending <= 8'h00;
            r_mask    <= 8'h00;
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_intr    <= 1'b0;
        end else begin
            r_s1 <= SRC;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            // A fresh edge outranks a simultaneous write-1-to-clear so it is never lost.
            r_pending <= (r_pending & ~w_clr_bits) | w_edge;
            if (w_mask_wr) begin
                r_mask <= OUT_PORT;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_active != 8'h00) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= CNT_LOAD;
                        r_intr  <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_SERVICE;
                        r_intr  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SERVICE: begin
                    // Any CLEAR_ID write, even with zero data, is the ISR acknowledge.
                    if (w_clr_wr) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign IN_DATA = (PORT_ID == STATUS_ID) ? r_pending : 8'h00;
    assign INTR    = r_intr;
    assign PENDING = r_pending;
    assign MASK    = r_mask;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Scoreboard bench for rat_int_ctrl: stimulus queues expected states, a negedge monitor compares.
module tb_rat_int_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       RESET_N4;
    logic [7:0] SRC;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;

    logic [7:0] IN_DATA,  IN_DATA4;
    logic       INTR,     INTR4;
    logic [7:0] PENDING,  PENDING4;
    logic [7:0] MASK,     MASK4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    rat_int_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .SRC(SRC), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .IN_DATA(IN_DATA),
        .INTR(INTR), .PENDING(PENDING), .MASK(MASK)
    );

    rat_int_ctrl #(.INTR_CYCLES(4)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N4), .SRC(SRC), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .IN_DATA(IN_DATA4),
        .INTR(INTR4), .PENDING(PENDING4), .MASK(MASK4)
    );

    typedef struct {
        string      name;
        bit         d4;
        bit         rd;
        logic [7:0] data;
        logic       intr;
        logic [7:0] pend;
        logic [7:0] mask;
    } exp_t;

    exp_t q[$];

    // Monitor: every queued expectation is due at the negedge following its push.
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [7:0] a_in, a_pend, a_mask;
            logic       a_intr;
            e      = q.pop_front();
            a_in   = e.d4 ? IN_DATA4 : IN_DATA;
            a_intr = e.d4 ? INTR4 : INTR;
            a_pend = e.d4 ? PENDING4 : PENDING;
            a_mask = e.d4 ? MASK4 : MASK;
            n_cmp++;
            if (e.rd) begin
                if (a_in !== e.data) begin
                    n_bad++;
                    $display("FAIL %s: IN_DATA got %02h want %02h", e.name, a_in, e.data);
                end
            end else if ({a_intr, a_pend, a_mask} !== {e.intr, e.pend, e.mask}) begin
                n_bad++;
                $display("FAIL %s: got intr=%0b pend=%02h mask=%02h want intr=%0b pend=%02h mask=%02h",
                         e.name, a_intr, a_pend, a_mask, e.intr, e.pend, e.mask);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_st(input string name, input bit d4, input logic intr,
                          input logic [7:0] pend, input logic [7:0] mask);
        exp_t e;
        e.name = name; e.d4 = d4; e.rd = 1'b0; e.data = 8'h00;
        e.intr = intr; e.pend = pend; e.mask = mask;
        q.push_back(e);
    endtask

    task automatic read_chk(input string name, input logic [7:0] id, input logic [7:0] data);
        exp_t e;
        PORT_ID = id;
        e.name = name; e.d4 = 1'b0; e.rd = 1'b1; e.data = data;
        e.intr = 1'b0; e.pend = 8'h00; e.mask = 8'h00;
        q.push_back(e);
        step();
    endtask

    task automatic bus_wr(input logic [7:0] id, input logic [7:0] data);
        PORT_ID  = id;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        step();
        IO_STRB  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; RESET_N4 = 1'b0;
        SRC = 8'hFF; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;

        // Reset with all sources high, then release: held-high sources record an edge.
        step(); step(); step();
        exp_st("rst_state", 0, 1'b0, 8'h00, 8'h00);
        exp_st("rst_state4", 1, 1'b0, 8'h00, 8'h00);
        read_chk("rst_in_data", 8'h00, 8'h00);
        RESET_N = 1'b1;
        step(); step();
        exp_st("rel_e1", 0, 1'b0, 8'h00, 8'h00);
        step();
        exp_st("rel_e2_pend", 0, 1'b0, 8'hFF, 8'h00);
        SRC = 8'h00;
        bus_wr(8'h45, 8'hFF);
        exp_st("rel_clear", 0, 1'b0, 8'h00, 8'h00);

        // Basic interrupt on SRC[0]
        bus_wr(8'h44, 8'h01);
        exp_st("basic_mask", 0, 1'b0, 8'h00, 8'h01);
        SRC = 8'h01;
        step(); step(); step();
        exp_st("basic_e2", 0, 1'b0, 8'h01, 8'h01);
        step();
        exp_st("basic_e3", 0, 1'b1, 8'h01, 8'h01);
        SRC = 8'h00;
        step();
        exp_st("basic_e4", 0, 1'b1, 8'h01, 8'h01);
        step();
        exp_st("basic_e5", 0, 1'b0, 8'h01, 8'h01);
        step();
        exp_st("basic_e6", 0, 1'b0, 8'h01, 8'h01);
        read_chk("basic_status", 8'h21, 8'h01);
        read_chk("basic_other_rd", 8'h20, 8'h00);
        bus_wr(8'h45, 8'h01);
        exp_st("basic_clear", 0, 1'b0, 8'h00, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_st("basic_quiet", 0, 1'b0, 8'h00, 8'h01);
        end

        // Hold-off while in SERVICE, re-arm after acknowledge
        bus_wr(8'h44, 8'h03);
        SRC = 8'h01;
        step(); step(); step(); step();
        exp_st("hold_first", 0, 1'b1, 8'h01, 8'h03);
        SRC = 8'h00;
        step(); step();
        exp_st("hold_service", 0, 1'b0, 8'h01, 8'h03);
        SRC = 8'h02;
        step(); step(); step();
        exp_st("hold_src1", 0, 1'b0, 8'h03, 8'h03);
        SRC = 8'h00;
        step();
        exp_st("hold_wait1", 0, 1'b0, 8'h03, 8'h03);
        step();
        exp_st("hold_wait2", 0, 1'b0, 8'h03, 8'h03);
        bus_wr(8'h45, 8'h01);
        exp_st("hold_ack", 0, 1'b0, 8'h02, 8'h03);
        step();
        exp_st("hold_rearm", 0, 1'b1, 8'h02, 8'h03);
        step(); step();
        exp_st("hold_end", 0, 1'b0, 8'h02, 8'h03);
        bus_wr(8'h45, 8'hFF);
        exp_st("hold_clear", 0, 1'b0, 8'h00, 8'h03);

        // Set and clear of bit 2 in the same cycle: set wins
        SRC = 8'h04;
        step(); step();
        bus_wr(8'h45, 8'h04);
        exp_st("setclr_same", 0, 1'b0, 8'h04, 8'h03);
        SRC = 8'h00;
        bus_wr(8'h45, 8'h04);
        exp_st("setclr_after", 0, 1'b0, 8'h00, 8'h03);

        // Masked latch, unrelated writes, late unmask
        bus_wr(8'h44, 8'h00);
        SRC = 8'h20;
        step(); step(); step();
        exp_st("masked_latch", 0, 1'b0, 8'h20, 8'h00);
        SRC = 8'h00;
        step();
        exp_st("masked_quiet", 0, 1'b0, 8'h20, 8'h00);
        bus_wr(8'h40, 8'hFF);
        exp_st("leds_write", 0, 1'b0, 8'h20, 8'h00);
        PORT_ID = 8'h44; OUT_PORT = 8'hFF; IO_STRB = 1'b0;
        step();
        exp_st("nostrb_mask", 0, 1'b0, 8'h20, 8'h00);
        PORT_ID = 8'h45;
        step();
        exp_st("nostrb_clear", 0, 1'b0, 8'h20, 8'h00);
        read_chk("masked_status", 8'h21, 8'h20);
        bus_wr(8'h44, 8'h20);
        exp_st("unmask_edge", 0, 1'b0, 8'h20, 8'h20);
        step();
        exp_st("unmask_intr", 0, 1'b1, 8'h20, 8'h20);
        step();
        exp_st("unmask_intr2", 0, 1'b1, 8'h20, 8'h20);
        step();
        exp_st("unmask_done", 0, 1'b0, 8'h20, 8'h20);
        bus_wr(8'h45, 8'h20);
        exp_st("unmask_clear", 0, 1'b0, 8'h00, 8'h20);

        // Reset in the middle of a 4-cycle pulse
        RESET_N4 = 1'b1;
        bus_wr(8'h44, 8'h01);
        exp_st("r4_mask", 1, 1'b0, 8'h00, 8'h01);
        SRC = 8'h01;
        step(); step(); step();
        exp_st("r4_pend", 1, 1'b0, 8'h01, 8'h01);
        step();
        exp_st("r4_intr1", 1, 1'b1, 8'h01, 8'h01);
        step();
        exp_st("r4_intr2", 1, 1'b1, 8'h01, 8'h01);
        RESET_N4 = 1'b0;
        step();
        exp_st("r4_reset", 1, 1'b0, 8'h00, 8'h00);
        SRC = 8'h00;
        step();
        exp_st("r4_held", 1, 1'b0, 8'h00, 8'h00);

        step(); step();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rat_int_ctrl.md
# rat_int_ctrl

Interrupt controller for the RAT MCU. It latches rising edges from up to eight external sources, gates them through a port-writable mask, and drives the MCU interrupt input with a stretched pulse. It then holds off further interrupts until the ISR acknowledges through an output port write. It sits in the top-level wrapper beside the input mux and output registers, sharing the MCU port bus: `PORT_ID`, `OUT_PORT`, `IO_STRB` and the input-port read path.

## Interface
Parameters:
- `MASK_ID`, `8'h44`: output port ID; a write loads the mask register.
- `CLEAR_ID`, `8'h45`: output port ID; a write clears pending bits (write-1-to-clear) and acknowledges the interrupt.
- `STATUS_ID`, `8'h21`: input port ID; a read returns the pending register.
- `INTR_CYCLES`, `2`: `INTR` pulse length in `CLK` cycles, range 1–15. The default of 2 covers one 50 MHz MCU edge.

Ports:
- `CLK`, in, 1: system clock (100 MHz). Single clock domain.
- `RESET_N`, in, 1: synchronous, active-low reset. Sampled on rising `CLK`.
- `SRC`, in, 8: raw interrupt sources. Asynchronous to `CLK`.
- `PORT_ID`, in, 8: MCU port ID.
- `OUT_PORT`, in, 8: MCU output data.
- `IO_STRB`, in, 1: MCU output strobe. A write occurs on any `CLK` edge where it is 1.
- `IN_DATA`, out, 8: combinational. Equals `pending` when `PORT_ID == STATUS_ID`, otherwise `8'h00`. It is OR-ed into the wrapper input mux.
- `INTR`, out, 1: registered interrupt request to the MCU.
- `PENDING`, out, 8: registered pending bits, for debug/LEDs.
- `MASK`, out, 8: registered mask.

## Operation
- **Synchronizer:** three flops per bit (`s1`, `s2`, `s3`). `edge[i] = s2[i] & ~s3[i]`. Only rising edges are recorded. Level-high inputs do not retrigger.
- **Pending:**
  - `pending[i]` is set on `edge[i]` regardless of the mask, so a later unmask fires immediately.
  - It is cleared when `IO_STRB & PORT_ID == CLEAR_ID & OUT_PORT[i]`.
  - If set and clear coincide in the same cycle, set wins.
- **Mask:** loaded with `OUT_PORT` when `IO_STRB & PORT_ID == MASK_ID`. A value of 1 enables the source.
- **Active:** `active = pending & mask`.
- **FSM**, 3 states:
  - `IDLE`: `INTR = 0`. If `active != 0`, go to `ASSERT` and load `cnt = INTR_CYCLES-1`.
  - `ASSERT`: `INTR = 1`. If `cnt == 0`, go to `SERVICE`; otherwise `cnt--`. A `CLEAR_ID` write here updates `pending` but does not end the pulse or count as an acknowledge.
  - `SERVICE`: `INTR = 0`. A `CLEAR_ID` write with any data, including `8'h00`, goes to `IDLE`. All other events are ignored; new edges still latch into `pending`.
- **Re-arm:** after returning to `IDLE`, a non-zero `active` re-enters `ASSERT` on the next edge. This gives at least one `INTR = 0` cycle between pulses.
- **Unrelated ports:** writes to port IDs other than `MASK_ID`/`CLEAR_ID` have no effect. `IO_STRB = 0` means no write, whatever `PORT_ID` holds.
- **Reset values** (`RESET_N = 0` at a `CLK` edge):
  - Registers: `pending = 0`, `mask = 0`, sync flops `= 0`, state `IDLE`, `cnt = 0`.
  - Outputs: `INTR = 0`, `PENDING = 8'h00`, `MASK = 8'h00`.
  - `IN_DATA` is `8'h00` unless `PORT_ID == STATUS_ID`.
  - Reset mid-`ASSERT`: `INTR` is 0 after that edge.
  - A source held high through reset release is recorded as an edge, because `s3` resets to 0.

## Timing
- `SRC[i]` rises and is stable before edge E0:
  - E1: `s2` set.
  - E2: `pending[i]` set.
  - E3: state `ASSERT`, `INTR = 1` (if unmasked and `IDLE`).
  - Total source-to-`INTR` latency: 3 `CLK` edges.
- `INTR` stays high for exactly `INTR_CYCLES` `CLK` cycles.
- `MASK`/`PENDING` update on the same edge that samples the write strobe.
- **Unmask-to-`INTR` latency:** 1 edge from `pending` already set and `IDLE`.
- **Status reads:** `IN_DATA` is combinational from `PORT_ID` with zero latency. Reads have no side effect.
- Minimum source pulse width is 2 `CLK` cycles. Shorter pulses may be missed.

## Test plan
- **Reset and defaults:** hold `RESET_N = 0` for 3 cycles with `SRC = 8'hFF` → `INTR = 0`, `PENDING = 0`, `MASK = 0`. Release → `PENDING = 8'hFF` 2 edges later, `INTR` stays 0 (masked).
- **Basic interrupt:**
  - Write `MASK_ID = 8'h01`, then pulse `SRC[0]` for 4 cycles → `PENDING = 8'h01` at E2 and `INTR` high for exactly 2 cycles from E3.
  - Read `STATUS_ID` → `IN_DATA = 8'h01`.
  - Write `CLEAR_ID = 8'h01` → `PENDING = 0`, state `IDLE`, no further `INTR`.
- **Hold-off and re-arm:** with mask `8'h03`, fire `SRC[0]`, then fire `SRC[1]` while in `SERVICE` → no second pulse until a `CLEAR_ID = 8'h01` write. Then `INTR` re-asserts 1 edge after the write, with `PENDING = 8'h02`.
- **Simultaneous set/clear:** align the `SRC[2]` edge detection with a `CLEAR_ID = 8'h04` write → `PENDING[2]` remains 1.
- **Masked latch, late unmask:** `SRC[5]` edge with mask 0 → `PENDING = 8'h20`, `INTR = 0`. Write `MASK_ID = 8'h20` → `INTR = 1` one edge later. Write to `8'h40` (LEDS) → no change to mask/pending.
- **Reset mid-pulse:** `INTRCYCLES=4`, assert `RESET_N = 0` on the second `INTR` cycle → `INTR = 0` and all registers 0 after that edge.
